// File: rtl/instruction_fetch_unit_if.sv
// Fetch-stage bus bundle: PC handshake, instruction memory port and the
// valid/ready delivery channel towards decode.
interface instruction_fetch_unit_if #(
    parameter int ADDR_W  = 16,
    parameter int INSTR_W = 16
);
    logic [ADDR_W-1:0]  pc;
    logic               pc_en;
    logic               flush;
    logic               imem_rd_en;
    logic [ADDR_W-1:0]  imem_addr;
    logic [INSTR_W-1:0] imem_rdata;
    logic [INSTR_W-1:0] instr;
    logic [ADDR_W-1:0]  instr_pc;
    logic               instr_valid;
    logic               instr_ready;

    // Fetch unit side
    modport master (
        input  pc, flush, imem_rdata, instr_ready,
        output pc_en, imem_rd_en, imem_addr, instr, instr_pc, instr_valid
    );

    // Surrounding pipeline side (PC, memory, control, decode)
    modport slave (
        output pc, flush, imem_rdata, instr_ready,
        input  pc_en, imem_rd_en, imem_addr, instr, instr_pc, instr_valid
    );
endinterface

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: issues one read per cycle to a 1-cycle-latency
// instruction memory, advances the PC only when a read issues (or on a
// redirect), and buffers returned words in a 2-entry queue for decode.
// Issue is credit-based: queued + in-flight words never exceed two, so the
// queue cannot overflow and the PC stalls naturally under backpressure.
module instruction_fetch_unit #(
    parameter int ADDR_W  = 16,
    parameter int INSTR_W = 16
) (
    input  logic                     sys_clock,
    input  logic                     reset,
    instruction_fetch_unit_if.master bus
);

    logic [1:0]         r_count;
    logic               r_inflight;
    logic [ADDR_W-1:0]  r_inflight_pc;
    logic [INSTR_W-1:0] r_q_instr [2];
    logic [ADDR_W-1:0]  r_q_pc    [2];

    logic               w_valid;
    logic               w_pop;
    logic               w_push;
    logic               w_issue;
    logic [2:0]         w_credit;

    assign w_valid = (r_count != 2'd0);

    // Handshake decode and issue credit check
    always_comb begin
        w_pop    = 1'b0;
        w_push   = 1'b0;
        w_issue  = 1'b0;
        w_credit = {1'b0, r_count} + {2'b00, r_inflight};
        if (w_valid && bus.instr_ready) begin
            w_pop = 1'b1;
        end else begin
            w_pop = 1'b0;
        end
        w_credit = {1'b0, r_count} + {2'b00, r_inflight} - {2'b00, w_pop};
        if (!bus.flush && !reset && (w_credit < 3'd2)) begin
            w_issue = 1'b1;
        end else begin
            w_issue = 1'b0;
        end
        // A flush discards the word returning this cycle
        if (r_inflight && !bus.flush) begin
            w_push = 1'b1;
        end else begin
            w_push = 1'b0;
        end
    end

    // The PC port is combinational so a fetch can issue every cycle;
    // reset forces everything low immediately
    assign bus.imem_rd_en  = w_issue;
    assign bus.pc_en       = ~reset & (w_issue | bus.flush);
    assign bus.imem_addr   = reset ? {ADDR_W{1'b0}} : bus.pc;
    assign bus.instr_valid = w_valid;
    assign bus.instr       = r_q_instr[0];
    assign bus.instr_pc    = r_q_pc[0];

    // Track the single outstanding memory read and its address
    always_ff @(posedge sys_clock or posedge reset) begin
        if (reset) begin
            r_inflight    <= 1'b0;
            r_inflight_pc <= {ADDR_W{1'b0}};
        end else begin
            r_inflight <= w_issue;
            if (w_issue) begin
                r_inflight_pc <= bus.pc;
            end
        end
    end

    // Two-entry queue; entry 0 is always the head presented to decode
    always_ff @(posedge sys_clock or posedge reset) begin
        if (reset) begin
            r_count      <= 2'd0;
            r_q_instr[0] <= {INSTR_W{1'b0}};
            r_q_instr[1] <= {INSTR_W{1'b0}};
            r_q_pc[0]    <= {ADDR_W{1'b0}};
            r_q_pc[1]    <= {ADDR_W{1'b0}};
        end else if (bus.flush) begin
            r_count <= 2'd0;
        end else begin
            case ({w_push, w_pop})
                2'b10: begin
                    if (r_count == 2'd0) begin
                        r_q_instr[0] <= bus.imem_rdata;
                        r_q_pc[0]    <= r_inflight_pc;
                    end else begin
                        r_q_instr[1] <= bus.imem_rdata;
                        r_q_pc[1]    <= r_inflight_pc;
                    end
                    r_count <= r_count + 2'd1;
                end
                2'b01: begin
                    // Only shift when a second entry exists so the head
                    // keeps its last value once the queue drains
                    if (r_count == 2'd2) begin
                        r_q_instr[0] <= r_q_instr[1];
                        r_q_pc[0]    <= r_q_pc[1];
                    end
                    r_count <= r_count - 2'd1;
                end
                2'b11: begin
                    if (r_count == 2'd1) begin
                        r_q_instr[0] <= bus.imem_rdata;
                        r_q_pc[0]    <= r_inflight_pc;
                    end else begin
                        r_q_instr[0] <= r_q_instr[1];
                        r_q_pc[0]    <= r_q_pc[1];
                        r_q_instr[1] <= bus.imem_rdata;
                        r_q_pc[1]    <= r_inflight_pc;
                    end
                end
                default: begin
                    r_count <= r_count;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit: models the PC (with jump load)
// and a 1-cycle synchronous instruction memory holding 0x1000 + address.
module tb_instruction_fetch_unit;

    logic        sys_clock = 1'b0;
    logic        reset     = 1'b1;
    logic [15:0] pc_q      = 16'h0000;
    logic [15:0] rdata_q   = 16'h0000;
    logic [15:0] jump_value = 16'h0000;
    int          n_checks  = 0;
    int          n_fail    = 0;

    instruction_fetch_unit_if #(.ADDR_W(16), .INSTR_W(16)) bus ();

    instruction_fetch_unit #(.ADDR_W(16), .INSTR_W(16)) dut (
        .sys_clock (sys_clock),
        .reset     (reset),
        .bus       (bus)
    );

    // Free-running clock, period 10
    initial begin
        forever #5 sys_clock = ~sys_clock;
    end

    // Program counter model: loads the jump target on flush, else increments on pc_en
    always @(posedge sys_clock or posedge reset) begin
        if (reset) begin
            pc_q <= 16'h0000;
        end else if (bus.pc_en) begin
            pc_q <= bus.flush ? jump_value : (pc_q + 16'd1);
        end
    end
    assign bus.pc = pc_q;

    // Synchronous instruction memory, word at address a is 0x1000 + a
    always @(posedge sys_clock) begin
        if (bus.imem_rd_en) begin
            rdata_q <= 16'h1000 + bus.imem_addr;
        end
    end
    assign bus.imem_rdata = rdata_q;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic cyc();
        @(negedge sys_clock);
    endtask

    initial begin
        bus.flush       = 1'b0;
        bus.instr_ready = 1'b1;

        // Reset state
        cyc(); cyc(); #1;
        check_eq("rst_valid", bus.instr_valid, 32'd0);
        check_eq("rst_pc_en", bus.pc_en, 32'd0);
        check_eq("rst_rd_en", bus.imem_rd_en, 32'd0);
        check_eq("rst_instr", bus.instr, 32'd0);
        check_eq("rst_instr_pc", bus.instr_pc, 32'd0);
        check_eq("rst_addr", bus.imem_addr, 32'd0);

        // Release: fetch starts at 0, first word visible two cycles later
        cyc(); reset = 1'b0; #1;
        check_eq("t1_rd_en0", bus.imem_rd_en, 32'd1);
        check_eq("t1_pc_en0", bus.pc_en, 32'd1);
        check_eq("t1_addr0", bus.imem_addr, 32'd0);
        check_eq("t1_valid0", bus.instr_valid, 32'd0);
        for (int k = 1; k <= 5; k++) begin
            cyc(); #1;
            check_eq("t1_addr", bus.imem_addr, k);
            if (k >= 2) begin
                check_eq("t1_valid", bus.instr_valid, 32'd1);
                check_eq("t1_instr_pc", bus.instr_pc, k - 2);
                check_eq("t1_instr", bus.instr, 32'h1000 + k - 2);
            end else begin
                check_eq("t1_valid_lat", bus.instr_valid, 32'd0);
            end
        end

        // Backpressure for 5 cycles: buffer fills, PC holds at 6
        cyc(); bus.instr_ready = 1'b0; #1;
        check_eq("t2_pc_en_stall", bus.pc_en, 32'd0);
        check_eq("t2_head", bus.instr_pc, 32'd4);
        for (int k = 7; k <= 10; k++) begin
            cyc(); #1;
            check_eq("t2_pc_en_hold", bus.pc_en, 32'd0);
            check_eq("t2_rd_en_hold", bus.imem_rd_en, 32'd0);
            check_eq("t2_addr_hold", bus.imem_addr, 32'd6);
            check_eq("t2_head_hold", bus.instr_pc, 32'd4);
            check_eq("t2_valid_hold", bus.instr_valid, 32'd1);
        end
        cyc(); bus.instr_ready = 1'b1; #1;
        check_eq("t2_resume_head", bus.instr_pc, 32'd4);
        check_eq("t2_resume_pc_en", bus.pc_en, 32'd1);
        check_eq("t2_resume_addr", bus.imem_addr, 32'd6);
        for (int k = 12; k <= 14; k++) begin
            cyc(); #1;
            check_eq("t2_valid", bus.instr_valid, 32'd1);
            check_eq("t2_instr_pc", bus.instr_pc, k - 7);
            check_eq("t2_instr", bus.instr, 32'h1000 + k - 7);
        end

        // Flush to 0x0040 with queue non-empty and a read in flight
        bus.instr_ready = 1'b0; bus.flush = 1'b1; jump_value = 16'h0040; #1;
        check_eq("t3_flush_pc_en", bus.pc_en, 32'd1);
        check_eq("t3_flush_rd_en", bus.imem_rd_en, 32'd0);
        cyc(); bus.flush = 1'b0; bus.instr_ready = 1'b1; #1;
        check_eq("t3_valid_clr", bus.instr_valid, 32'd0);
        check_eq("t3_addr", bus.imem_addr, 32'h0040);
        check_eq("t3_rd_en", bus.imem_rd_en, 32'd1);
        cyc(); #1;
        check_eq("t3_no_stale", bus.instr_valid, 32'd0);
        cyc(); #1;
        check_eq("t3_valid", bus.instr_valid, 32'd1);
        check_eq("t3_instr_pc", bus.instr_pc, 32'h0040);
        check_eq("t3_instr", bus.instr, 32'h1040);

        // Flush coinciding with a pop
        bus.flush = 1'b1; jump_value = 16'h0080; #1;
        check_eq("t4a_pc_en", bus.pc_en, 32'd1);
        check_eq("t4a_rd_en", bus.imem_rd_en, 32'd0);
        cyc(); bus.flush = 1'b0; #1;
        check_eq("t4a_valid_clr", bus.instr_valid, 32'd0);
        check_eq("t4a_addr", bus.imem_addr, 32'h0080);
        cyc(); #1;
        check_eq("t4a_no_stale", bus.instr_valid, 32'd0);
        cyc(); #1;
        check_eq("t4a_instr_pc", bus.instr_pc, 32'h0080);
        check_eq("t4a_instr", bus.instr, 32'h1080);

        // Flush while stalled with a full queue, jumping near the top of memory
        bus.instr_ready = 1'b0;
        cyc(); #1;
        check_eq("t4b_full_pc_en", bus.pc_en, 32'd0);
        check_eq("t4b_full_head", bus.instr_pc, 32'h0080);
        bus.flush = 1'b1; jump_value = 16'hFFFE; #1;
        check_eq("t4b_flush_pc_en", bus.pc_en, 32'd1);
        cyc(); bus.flush = 1'b0; bus.instr_ready = 1'b1; #1;
        check_eq("t4b_valid_clr", bus.instr_valid, 32'd0);
        check_eq("t5_addr0", bus.imem_addr, 32'hFFFE);
        cyc(); #1;
        check_eq("t5_addr1", bus.imem_addr, 32'hFFFF);
        check_eq("t4b_no_stale", bus.instr_valid, 32'd0);
        cyc(); #1;
        check_eq("t5_addr2", bus.imem_addr, 32'h0000);
        check_eq("t5_pc0", bus.instr_pc, 32'hFFFE);
        check_eq("t5_instr0", bus.instr, 32'h0FFE);
        cyc(); #1;
        check_eq("t5_pc1", bus.instr_pc, 32'hFFFF);
        check_eq("t5_instr1", bus.instr, 32'h0FFF);
        cyc(); #1;
        check_eq("t5_pc2", bus.instr_pc, 32'h0000);
        check_eq("t5_instr2", bus.instr, 32'h1000);

        // Asynchronous reset between clock edges
        #2; reset = 1'b1; #1;
        check_eq("t6_valid", bus.instr_valid, 32'd0);
        check_eq("t6_pc_en", bus.pc_en, 32'd0);
        check_eq("t6_rd_en", bus.imem_rd_en, 32'd0);
        cyc(); reset = 1'b0; #1;
        check_eq("t6_addr", bus.imem_addr, 32'd0);
        check_eq("t6_rd_en_rel", bus.imem_rd_en, 32'd1);
        cyc(); cyc(); #1;
        check_eq("t6_valid_rel", bus.instr_valid, 32'd1);
        check_eq("t6_instr_pc", bus.instr_pc, 32'd0);
        check_eq("t6_instr", bus.instr, 32'h1000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
